// File: rtl/mips_pkg.sv
// Shared constants for the fetch unit, the IF/ID queue and the decoder.
package mips_pkg;

    // First PC of the text segment; fetch starts here after reset.
    localparam logic [31:0] RESET_PC    = 32'h0000_3000;

    // Encoding presented to decode whenever no real instruction is available.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    // Offset from a link instruction's PC to the return address it writes.
    localparam logic [31:0] PC_LINK_OFS = 32'h0000_0008;

endpackage

// File: rtl/if_id_queue.sv
// Fetch/decode decoupling queue: holds {pc, instr} pairs from fetch and hands
// them to decode in order, with a flush for control-flow redirects and a
// precomputed pc+8 link value for jal/jalr.
module if_id_queue
    import mips_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [PC_W-1:0]            out_pc8,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]        FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [PC_W-1:0]    LINK_OFS   = PC_W'(PC_LINK_OFS);
    localparam logic [INSTR_W-1:0] EMPTY_INSTR = INSTR_W'(NOP_INSTR);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occupancy;

    logic push;
    logic pop;

    // Handshake decode; flush overrides both so the wrong-path word is dropped.
    always_comb begin
        in_ready  = (occupancy != FULL_COUNT);
        out_valid = (occupancy != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // Storage write; contents are never cleared since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // Pointer and occupancy bookkeeping with immediate clear on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rd_ptr    <= wr_ptr;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    // Head presentation: a nop at PC 0 when empty so stale storage never leaks.
    always_comb begin
        out_pc    = '0;
        out_instr = EMPTY_INSTR;
        if (out_valid) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end
        out_pc8 = out_pc + LINK_OFS;
        count   = occupancy;
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a vector table for the directed
// sequence, a queue-based scoreboard that tracks every accepted word, and a
// few hand-written corner sequences (random back-pressure, pc+8 wrap, reset).
module tb_if_id_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc8;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_pc    [$];
    logic [31:0] sb_instr [$];
    int          m_count  = 0;
    int          popped   = 0;

    typedef struct {
        logic        v;
        logic        r;
        logic        f;
        logic [31:0] pc;
        int          exp_count;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [13];

    if_id_queue #(.DEPTH(4), .PC_W(32), .INSTR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_pc8   (out_pc8),
        .out_instr (out_instr),
        .count     (count)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h3408_0001 + ((pc - 32'h3000) >> 2);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the scoreboard model.
    task automatic check_state(input string tag);
        logic [31:0] hp;
        logic [31:0] hi;
        hp = (m_count != 0) ? sb_pc[0] : 32'h0;
        hi = (m_count != 0) ? sb_instr[0] : 32'h0;
        check_output({tag, ".count"},     {29'b0, count},     m_count);
        check_output({tag, ".in_ready"},  {31'b0, in_ready},  (m_count != 4) ? 32'd1 : 32'd0);
        check_output({tag, ".out_valid"}, {31'b0, out_valid}, (m_count != 0) ? 32'd1 : 32'd0);
        check_output({tag, ".out_pc"},    out_pc,    hp);
        check_output({tag, ".out_pc8"},   out_pc8,   hp + 32'd8);
        check_output({tag, ".out_instr"}, out_instr, hi);
    endtask

    // Drive one cycle of inputs, update the model, and check after the edge.
    task automatic apply_stimulus(input string tag, input logic v, input logic r, input logic f,
                                  input logic [31:0] pc, input logic [31:0] instr);
        bit push_ok;
        bit pop_ok;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_pc     = pc;
        in_instr  = instr;
        push_ok   = v && (m_count != 4) && !f;
        pop_ok    = (m_count != 0) && r && !f;
        if (pop_ok) begin
            check_output({tag, ".pop_pc"},    out_pc,    sb_pc[0]);
            check_output({tag, ".pop_instr"}, out_instr, sb_instr[0]);
            void'(sb_pc.pop_front());
            void'(sb_instr.pop_front());
            popped++;
        end
        if (push_ok) begin
            sb_pc.push_back(pc);
            sb_instr.push_back(instr);
        end
        if (f) begin
            sb_pc.delete();
            sb_instr.delete();
        end
        m_count = sb_pc.size();
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_pc     = 32'h0;
        in_instr  = 32'h0;

        // Directed sequence: fill, full stall, pop-only when full, steady
        // push+pop at 3, flush with concurrent traffic, push while empty.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h3000, 1, 1'b1, 1'b1, 32'h3000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h3004, 2, 1'b1, 1'b1, 32'h3000};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h3008, 3, 1'b1, 1'b1, 32'h3000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h300C, 4, 1'b0, 1'b1, 32'h3000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h3010, 4, 1'b0, 1'b1, 32'h3000};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h3010, 3, 1'b1, 1'b1, 32'h3004};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h3010, 3, 1'b1, 1'b1, 32'h3008};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h3014, 3, 1'b1, 1'b1, 32'h300C};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h3018, 3, 1'b1, 1'b1, 32'h3010};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h301C, 0, 1'b1, 1'b0, 32'h0000};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000, 0, 1'b1, 1'b0, 32'h0000};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h3040, 1, 1'b1, 1'b1, 32'h3040};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0000, 0, 1'b1, 1'b0, 32'h0000};

        // Reset held for three cycles, then released.
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_low.out_valid", {31'b0, out_valid}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst.count",     {29'b0, count},    32'd0);
        check_output("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst.in_ready",  {31'b0, in_ready},  32'd1);
        check_output("rst.out_instr", out_instr, 32'h0);
        check_output("rst.out_pc",    out_pc,    32'h0);
        check_output("rst.out_pc8",   out_pc8,   32'h8);

        for (int i = 0; i < 13; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].v, vecs[i].r, vecs[i].f,
                           vecs[i].pc, instr_of(vecs[i].pc));
            check_output($sformatf("vec%0d.tbl_count", i), {29'b0, count}, vecs[i].exp_count);
            check_output($sformatf("vec%0d.tbl_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_ready});
            check_output($sformatf("vec%0d.tbl_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            check_output($sformatf("vec%0d.tbl_pc", i), out_pc, vecs[i].exp_pc);
            check_output($sformatf("vec%0d.tbl_pc8", i), out_pc8, vecs[i].exp_pc + 32'd8);
        end

        // Ten words through the queue with random back-pressure across pointer wrap.
        begin
            int sent;
            int cyc;
            logic [31:0] pc;
            sent   = 0;
            cyc    = 0;
            popped = 0;
            while ((sent < 10 || m_count != 0) && cyc < 300) begin
                pc = 32'h3100 + 32'(sent * 4);
                if (sent < 10) begin
                    if (m_count != 4) sent++;
                    apply_stimulus("rand", 1'b1, 1'($urandom_range(0, 1)), 1'b0, pc, instr_of(pc));
                end else begin
                    apply_stimulus("drain", 1'b0, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 32'h0);
                end
                cyc++;
            end
            check_output("rand.popped", popped, 32'd10);
        end

        // Link value wraps modulo 2^32.
        apply_stimulus("wrap_push", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF);
        check_output("wrap.out_pc8", out_pc8, 32'h0000_0004);
        apply_stimulus("wrap_pop", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        // Asynchronous reset mid-stream with two entries held.
        apply_stimulus("mid_push0", 1'b1, 1'b0, 1'b0, 32'h3200, instr_of(32'h3200));
        apply_stimulus("mid_push1", 1'b1, 1'b0, 1'b0, 32'h3204, instr_of(32'h3204));
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_output("async.out_valid", {31'b0, out_valid}, 32'd0);
        check_output("async.count",     {29'b0, count},    32'd0);
        check_output("async.out_pc8",   out_pc8, 32'h8);
        sb_pc.delete();
        sb_instr.delete();
        m_count = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_rst");
        apply_stimulus("post_rst_push", 1'b1, 1'b0, 1'b0, 32'h3300, instr_of(32'h3300));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
